// File: rtl/mdu_seq_if.sv
// mdu_seq_if: start/busy request bus and HI/LO read-out of the multiply/divide unit
interface mdu_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic cancel;
  logic busy;
  logic [2:0] MDUOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master(output start, cancel, MDUOp, SrcA, SrcB, input busy, HI, LO);
  modport slave(input start, cancel, MDUOp, SrcA, SrcB, output busy, HI, LO);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit owning HI/LO, with start/busy handshake and cancel
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_seq_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_DIVU = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;
  localparam logic [2:0] OP_MADD = 3'd7;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, hi, lo;
  logic [WIDTH-1:0] dd, dv, q, r;
  logic [2*WIDTH-1:0] sprod, uprod, res;
  logic is_div, neg_q, neg_r, wr;
  assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign neg_q = (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
  assign neg_r = (op == OP_DIV) && a[WIDTH-1];
  // signed divide works on magnitudes; MIN/-1 naturally wraps back to MIN with zero remainder
  assign dd = ((op == OP_DIV) && a[WIDTH-1]) ? -a : a;
  assign dv = (b == '0) ? WIDTH'(1) : (((op == OP_DIV) && b[WIDTH-1]) ? -b : b);
  assign q = dd / dv;
  assign r = dd % dv;
  assign wr = !(is_div && (b == '0));
  assign res = (op == OP_MULT) ? sprod :
               (op == OP_MULTU) ? uprod :
               (op == OP_MADD) ? {hi, lo} + sprod :
               {(neg_r ? -r : r), (neg_q ? -q : q)};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      op <= OP_NONE;
      a <= '0;
      b <= '0;
    end else if (state == IDLE) begin
      if (bus.start && !bus.cancel) begin
        if (bus.MDUOp == OP_MTHI) hi <= bus.SrcA;
        else if (bus.MDUOp == OP_MTLO) lo <= bus.SrcA;
        else if (bus.MDUOp != OP_NONE) begin
          state <= RUN;
          op <= bus.MDUOp;
          a <= bus.SrcA;
          b <= bus.SrcB;
          cnt <= (bus.MDUOp == OP_DIV || bus.MDUOp == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
    end else if (bus.cancel || cnt == CW'(1)) begin
      state <= IDLE;
      cnt <= '0;
      if (!bus.cancel && wr) {hi, lo} <= res;
    end else cnt <= cnt - CW'(1);
  end
  assign bus.busy = state == RUN;
  assign bus.HI = hi;
  assign bus.LO = lo;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed table, hand-written cancel/reset sequences and random ops against an arithmetic model
module tb_mdu_seq;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;
  mdu_seq_if #(.WIDTH(32)) bus();
  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ph, pl;
    logic [2:0] op;
    logic [31:0] a, b, eh, el;
    int cyc;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int cyc_of(input logic [2:0] op);
    return (op == 3 || op == 4) ? 10 : (op == 0 || op == 5 || op == 6) ? 0 : 5;
  endfunction

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int ai, bi;
    sp = longint'($signed(a)) * longint'($signed(b));
    ai = int'(a);
    bi = int'(b);
    case (op)
      1: {m_hi, m_lo} = 64'(sp);
      2: {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
      3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) {m_hi, m_lo} = {32'd0, 32'h8000_0000};
        else begin
          m_lo = 32'(ai / bi);
          m_hi = 32'(ai % bi);
        end
      end
      4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      5: m_hi = a;
      6: m_lo = a;
      7: {m_hi, m_lo} = {m_hi, m_lo} + 64'(sp);
      default: ;
    endcase
  endtask

  // operands are scrambled while busy to show the result depends only on latched values
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    bus.start = 1;
    bus.MDUOp = op;
    bus.SrcA = a;
    bus.SrcB = b;
    @(negedge clk);
    bus.start = 0;
    bus.MDUOp = 0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.SrcA = $urandom;
      bus.SrcB = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic preset(input logic [31:0] h, input logic [31:0] l);
    int n;
    issue(5, h, 0, n);
    issue(6, l, 0, n);
    m_hi = h;
    m_lo = l;
  endtask

  task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1;
    bus.MDUOp = op;
    bus.SrcA = a;
    bus.SrcB = b;
    @(negedge clk);
    bus.start = 0;
    bus.MDUOp = 0;
  endtask

  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] a, b;
    bus.start = 0;
    bus.cancel = 0;
    bus.MDUOp = 0;
    bus.SrcA = 0;
    bus.SrcB = 0;
    tbl[0] = '{32'h0, 32'h0, 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    tbl[1] = '{32'h0, 32'h0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 5};
    tbl[2] = '{32'h0, 32'h0, 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[3] = '{32'h0, 32'h0, 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10};
    tbl[4] = '{32'h5, 32'h5, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10};
    tbl[5] = '{32'h11, 32'h22, 3'd3, 32'd9, 32'd0, 32'h11, 32'h22, 10};
    tbl[6] = '{32'h0, 32'h10, 3'd7, 32'd3, 32'd4, 32'h0, 32'h1C, 5};
    tbl[7] = '{32'h0, 32'h0, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};
    tbl[8] = '{32'h0, 32'h0, 3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10};
    tbl[9] = '{32'h1, 32'h2, 3'd5, 32'hABC, 32'd0, 32'hABC, 32'h2, 0};
    tbl[10] = '{32'h3, 32'h4, 3'd4, 32'd100, 32'd0, 32'h3, 32'h4, 10};
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_hi", 64'(bus.HI), 0);
    chk("reset_lo", 64'(bus.LO), 0);
    reset = 0;
    for (int i = 0; i < 11; i++) begin
      preset(tbl[i].ph, tbl[i].pl);
      issue(tbl[i].op, tbl[i].a, tbl[i].b, n);
      chk($sformatf("tbl%0d_cycles", i), 64'(n), 64'(tbl[i].cyc));
      chk($sformatf("tbl%0d_hi", i), 64'(bus.HI), 64'(tbl[i].eh));
      chk($sformatf("tbl%0d_lo", i), 64'(bus.LO), 64'(tbl[i].el));
      m_hi = tbl[i].eh;
      m_lo = tbl[i].el;
    end
    // start held (as mthi) across the whole op, including the completion edge, is ignored
    preset(0, 0);
    @(negedge clk);
    bus.start = 1;
    bus.MDUOp = 1;
    bus.SrcA = 2;
    bus.SrcB = 3;
    @(negedge clk);
    bus.MDUOp = 5;
    bus.SrcA = 32'hDEAD;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("held_cycles", 64'(n), 5);
    chk("held_hi", 64'(bus.HI), 0);
    chk("held_lo", 64'(bus.LO), 6);
    bus.MDUOp = 6;
    bus.SrcA = 32'h77;
    @(negedge clk);
    bus.start = 0;
    bus.MDUOp = 0;
    chk("next_start_lo", 64'(bus.LO), 32'h77);
    chk("next_start_hi", 64'(bus.HI), 0);
    chk("next_start_busy", 64'(bus.busy), 0);
    // cancel on the third busy cycle
    preset(32'h5, 32'h6);
    start_only(1, 7, 9);
    repeat (2) @(negedge clk);
    chk("cancel3_busy_before", 64'(bus.busy), 1);
    bus.cancel = 1;
    @(negedge clk);
    bus.cancel = 0;
    chk("cancel3_busy", 64'(bus.busy), 0);
    repeat (6) @(negedge clk);
    chk("cancel3_hi", 64'(bus.HI), 32'h5);
    chk("cancel3_lo", 64'(bus.LO), 32'h6);
    // cancel exactly at the completion edge
    start_only(1, 7, 9);
    repeat (4) @(negedge clk);
    bus.cancel = 1;
    @(negedge clk);
    bus.cancel = 0;
    chk("cancel_end_busy", 64'(bus.busy), 0);
    chk("cancel_end_hi", 64'(bus.HI), 32'h5);
    chk("cancel_end_lo", 64'(bus.LO), 32'h6);
    // cancel alongside start in IDLE discards mthi and mult
    @(negedge clk);
    bus.cancel = 1;
    bus.start = 1;
    bus.MDUOp = 5;
    bus.SrcA = 32'h99;
    @(negedge clk);
    bus.MDUOp = 1;
    @(negedge clk);
    bus.cancel = 0;
    bus.start = 0;
    bus.MDUOp = 0;
    chk("idle_cancel_hi", 64'(bus.HI), 32'h5);
    chk("idle_cancel_busy", 64'(bus.busy), 0);
    // reset in the middle of a divide
    start_only(3, 100, 7);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid_busy", 64'(bus.busy), 0);
    chk("rst_mid_hi", 64'(bus.HI), 0);
    chk("rst_mid_lo", 64'(bus.LO), 0);
    repeat (10) @(negedge clk);
    chk("rst_mid_late", 64'({bus.HI, bus.LO}), 0);
    m_hi = 0;
    m_lo = 0;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(1, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      issue(op, a, b, n);
      model(op, a, b);
      chk($sformatf("rnd%0d_op%0d_cycles", i, op), 64'(n), 64'(cyc_of(op)));
      chk($sformatf("rnd%0d_op%0d_hilo", i, op), {bus.HI, bus.LO}, {m_hi, m_lo});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
